// File: rtl/cpu_run_ctrl.sv
// cpu_run_ctrl: debounced run/halt/single-step control gating the CPU clock-enable, with address breakpoint.
module cpu_run_ctrl #(
  parameter int ADDR_W   = 4,
  parameter int DEBOUNCE = 4
) (
  input  logic              clk,
  input  logic              n_rst,
  input  logic              run_btn,
  input  logic              step_btn,
  input  logic              halt_btn,
  input  logic              bp_en,
  input  logic [ADDR_W-1:0] bp_addr,
  input  logic [ADDR_W-1:0] pc,
  output logic              cpu_en,
  output logic              halted,
  output logic [7:0]        instr_cnt
);
  localparam int CW = $clog2(DEBOUNCE);
  typedef enum logic [1:0] {S_HALT, S_RUN, S_STEP} state_t;
  state_t     r_state;
  logic       r_armed;
  logic [2:0] w_raw;
  logic [2:0] w_pulse;
  logic       w_bp_hit;
  logic       w_stop;
  assign w_raw = {halt_btn, step_btn, run_btn};
  for (genvar g = 0; g < 3; g++) begin : g_db
    logic [CW-1:0] r_cnt;
    logic          r_db;
    logic          r_db_q;
    always_ff @(posedge clk) begin
      if (n_rst) begin
        r_cnt  <= '0;
        r_db   <= 1'b0;
        r_db_q <= 1'b0;
      end else begin
        r_db_q <= r_db;
        if (w_raw[g] == r_db) begin
          r_cnt <= '0;
        end else if (r_cnt == CW'(DEBOUNCE - 1)) begin
          r_db  <= w_raw[g];
          r_cnt <= '0;
        end else begin
          r_cnt <= r_cnt + 1'b1;
        end
      end
    end
    assign w_pulse[g] = r_db & ~r_db_q;
  end
  // armed blocks an immediate re-hit when resuming from the breakpoint address
  assign w_bp_hit = bp_en & r_armed & (pc == bp_addr);
  assign w_stop   = w_pulse[2] | w_bp_hit;
  assign cpu_en   = ~n_rst & ((r_state == S_STEP) | ((r_state == S_RUN) & ~w_stop));
  always_ff @(posedge clk) begin
    if (n_rst) begin
      r_state   <= S_HALT;
      halted    <= 1'b1;
      instr_cnt <= 8'd0;
      r_armed   <= 1'b0;
    end else begin
      instr_cnt <= instr_cnt + {7'd0, cpu_en};
      case (r_state)
        S_HALT: begin
          if (w_pulse[1]) begin
            r_state <= S_STEP;
            halted  <= 1'b0;
          end else if (w_pulse[0]) begin
            r_state <= S_RUN;
            halted  <= 1'b0;
            r_armed <= 1'b0;
          end
        end
        S_STEP: begin
          r_state <= S_HALT;
          halted  <= 1'b1;
        end
        S_RUN: begin
          if (w_stop) begin
            r_state <= S_HALT;
            halted  <= 1'b1;
          end else begin
            r_armed <= 1'b1;
          end
        end
        default: begin
          r_state <= S_HALT;
          halted  <= 1'b1;
        end
      endcase
    end
  end
endmodule

// File: doc/cpu_run_ctrl.md
# cpu_run_ctrl

Run/halt/single-step controller for the small teaching CPU. It sits between the board push-buttons and the CPU core, and gates CPU execution through a clock-enable. Buttons are debounced. An optional address breakpoint stops a free run when the program counter reaches a chosen address. An executed-instruction counter is provided for display on the LEDs.

## Interface
- `ADDR_W`, default 4: width of the program counter and breakpoint address.
- `DEBOUNCE`, default 4: number of consecutive identical samples (≥2) a button must hold before its debounced level changes.
- `clk  in  1`: single system clock; all state updates on its rising edge.
- `n_rst  in  1`: reset, synchronous, active-high. Asserted = 1; the name follows the existing CPU port.
- `run_btn  in  1`: raw run button, active-high.
- `step_btn  in  1`: raw single-step button, active-high.
- `halt_btn  in  1`: raw halt button, active-high.
- `bp_en  in  1`: breakpoint enable.
- `bp_addr  in  ADDR_W`: breakpoint address.
- `pc  in  ADDR_W`: current CPU program counter, registered inside the CPU.
- `cpu_en  out  1`: CPU clock-enable. The CPU executes one instruction on each edge where this is 1.
- `halted  out  1`: registered; 1 while the FSM is in HALT.
- `instr_cnt  out  8`: count of cycles with `cpu_en = 1`; wraps 255→0.

## Operation
- **Debounce (one instance per button).**
  - Sample counter and debounced level `db`, both reset to 0.
  - When raw ≠ `db`, the counter increments each edge. When raw = `db`, the counter clears.
  - When the counter reaches `DEBOUNCE−1` with raw still ≠ `db`, `db` takes the raw value at that edge and the counter clears.
  - Pulse = `db & ~db_q`, where `db_q` is `db` delayed one cycle. The pulse is 1 cycle wide, once per press.
  - A glitch shorter than `DEBOUNCE` samples produces no pulse.
- **FSM states:** HALT (reset state), RUN, STEP.
- **HALT:**
  - `cpu_en = 0`.
  - Step pulse → STEP. Run pulse → RUN. If both pulses occur together, step wins.
  - Halt pulse is ignored.
- **STEP:**
  - `cpu_en = 1` for exactly this one cycle, then → HALT unconditionally.
  - All button pulses in this cycle are ignored.
  - The breakpoint is not checked.
- **RUN:**
  - `cpu_en = ~stop`, where `stop = halt_pulse | bp_hit`.
  - If `stop`, → HALT. Otherwise stay in RUN.
  - Step and run pulses are ignored.
- **Breakpoint:**
  - `bp_hit = bp_en & armed & (pc == bp_addr)`. This is combinational, so `cpu_en` drops in the same cycle and the instruction at `bp_addr` is not executed.
  - `armed` clears on every entry to RUN. It sets after the first RUN cycle with `cpu_en = 1`.
  - Consequence: resuming from a breakpoint executes the instruction at `bp_addr` instead of re-halting immediately.
  - A breakpoint hit takes priority over nothing; it and a halt pulse have the same effect.
- **`instr_cnt`:** +1 on every edge where `cpu_en = 1`; 8-bit, modulo 256.
- **Reset (any state, including mid-RUN or mid-STEP):**
  - At the next edge: state = HALT, `halted = 1`, `instr_cnt = 0`, `armed = 0`, all debounce counters, `db` and `db_q` = 0.
  - While `n_rst = 1`, `cpu_en` is forced to 0 combinationally.

## Timing
- **Reset values:** `cpu_en = 0`, `halted = 1`, `instr_cnt = 0`.
- **Button latency:**
  - Raw button first sampled high at edge k and held → `db` = 1 after edge k+DEBOUNCE−1.
  - The pulse is visible during the following cycle. The FSM changes state at edge k+DEBOUNCE.
- **`halted`:** a registered copy of the state. It falls at the same edge the FSM leaves HALT and rises at the edge it enters HALT.
- **`cpu_en`:**
  - In RUN and STEP it is a combinational function of the state and the inputs listed under Operation.
  - The CPU must sample it on the same edge, with no extra pipeline delay.
- **Single step:** one press yields exactly one `cpu_en` cycle, so `pc` advances by one instruction.
- **Holding a button:** a button held indefinitely yields one pulse only; releasing and pressing again is needed for another pulse.

## Test plan
- **Reset:** assert `n_rst` for 2 cycles mid-RUN → `cpu_en = 0`, `halted = 1`, `instr_cnt = 0` after the next edge; FSM in HALT.
- **Step:** with `DEBOUNCE = 4`, press `step_btn` 10 cycles → exactly one `cpu_en` pulse, 4 edges after the first sample; `instr_cnt` 0→1; `halted` returns to 1.
- **Glitch:** `run_btn` high for 3 cycles then low → no pulse; state stays HALT; `cpu_en` never 1.
- **Breakpoint:**
  - Set `bp_en = 1`, `bp_addr = 5`, pc model incrementing on `cpu_en`, starting from 0; press run.
  - Required: `cpu_en` drops in the cycle `pc == 5`, → HALT, `instr_cnt = 5`.
  - Press run again → pc passes 5 without halting.
- **Free run and halt:**
  - Run with `bp_en = 0` for 300 enabled cycles → `instr_cnt` wraps to 44 (300 mod 256).
  - Then press halt → `cpu_en` = 0 in the pulse cycle; `halted = 1` next cycle.
- **Simultaneous presses:** `run_btn` and `step_btn` pressed together in HALT → STEP taken (one `cpu_en` cycle), then HALT. Pressing step during RUN has no effect.
